debounce_multi: RTL and testbench
=================================

Name: debounce_multi

Overview:
- Parametrised N-channel debouncer for front-panel buttons and slow external control lines. Successor to the fixed 5-button debouncer.
- Adds the following to the basic function:
  - 2-FF input synchroniser.
  - Selectable input polarity.
  - One-cycle rise/fall event pulses.
  - Per-channel long-press detection.
- Sits between the board pins and the run-control FSM.
- Downstream logic consumes the pulses directly instead of doing its own edge detection.

Parameters:
- N_CH, 5: number of independent channels.
- DB_CYCLES, 10: cycles the synchronised input must be stable before the output follows. Legal range ≥1; production builds set 500000.
- HOLD_CYCLES, 20: cycles the debounced output must stay high before `held` asserts. 0 disables long-press (`held` and `long_pulse` tied 0).
- ACTIVE_LOW, 0: 1 = inputs are inverted before the synchroniser, so the pressed level reads as 1 internally.

Ports:
- clock  in  1  system clock (100 MHz)
- reset  in  1  synchronous, active-high reset
- button  in  N_CH  raw asynchronous inputs
- out  out  N_CH  debounced level
- rise  out  N_CH  one-cycle pulse, same edge that `out[i]` goes 0→1
- fall  out  N_CH  one-cycle pulse, same edge that `out[i]` goes 1→0
- held  out  N_CH  level: `out[i]` has been 1 for HOLD_CYCLES cycles
- long_pulse  out  N_CH  one-cycle pulse on the edge `held[i]` sets

Behaviour:
- One clock domain; reset is synchronous and active-high. Reset (any cycle, including mid-count) clears:
  - sync FFs, candidate `iv`, `cnt`, `hcnt`;
  - `out`, `rise`, `fall`, `held`, `long_pulse` → all 0.
- Inversion for ACTIVE_LOW is applied before the synchroniser, so the reset value 0 always means "not pressed".
- Per channel, `s` is the output of the 2-FF synchroniser. Evaluated each edge, in this order:
  - If `s != iv`: `iv <= s`, `cnt <= 0`.
  - Else if `cnt == DB_CYCLES`: `out <= iv`.
  - Else: `cnt <= cnt + 1`.
- `cnt` width is clog2(DB_CYCLES+1) and saturates at DB_CYCLES, so it never wraps.
- Latency: an input change first sampled at edge k reaches `out` at edge k+DB_CYCLES+3, assuming no intervening change.
- Any input run shorter than DB_CYCLES+1 stable synchronised cycles produces no output change and no pulse.
- `rise`/`fall` are registered and asserted for exactly one cycle, on the same edge that `out` changes. Re-confirming an unchanged level gives no pulse.
- Long-press:
  - `hcnt` is held at 0 while `out` = 0, and is 0 on the edge `out` rises.
  - It increments each cycle while `out` = 1, saturating at HOLD_CYCLES.
  - When the increment reaches HOLD_CYCLES (edge R+HOLD_CYCLES, R = rise edge): `held <= 1` and `long_pulse` is asserted for 1 cycle.
  - `held` clears on the same edge `out` falls.
  - `long_pulse` fires at most once per press.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulses on the same edge.
- A press released after `held` set still produces a normal `fall`.

Decomposition:
- Package `debounce_pkg`: a clog2 helper function and default constants (DB_CYCLES_SIM=10, DB_CYCLES_HW=500000, HOLD default).
- Natural sub-module: `debounce_ch`, one channel containing the synchroniser, stability counter, edge pulses and hold counter.
- `debounce_multi` instantiates N_CH copies of `debounce_ch` in a generate loop and packs the vectors.

Test Plan (N_CH=5, DB_CYCLES=10, HOLD_CYCLES=20, ACTIVE_LOW=0 unless stated):
1. Reset, then `button[0]` 0→1 sampled at edge 0 and held → `out[0]`=1 and `rise[0]`=1 at edge 13; `rise[0]`=0 at edge 14; all other channels and `fall` stay 0.
2. `button[1]` high for 8 cycles, then low → `out[1]`, `rise[1]`, `fall[1]` never assert.
3. `button[2]` toggles every 3 cycles for 30 cycles, then stays high → exactly one `rise[2]`, 13 cycles after the final transition is sampled; no `fall[2]`.
4. `button[3]` high for 60 cycles, then low:
   - `rise` at edge 13;
   - `held[3]` and `long_pulse[3]` at edge 33;
   - `long_pulse` lasts 1 cycle;
   - `fall[3]` 13 cycles after release, with `held[3]` clearing on that edge.
5. `button[4]` high; `reset` pulsed at cycle 6 (mid-count) and at cycle 20 (after `out`=1):
   - all outputs 0 on the edge after each reset;
   - no pulses during reset;
   - `rise` reappears 13 cycles after reset deasserts.
6. ACTIVE_LOW=1, all buttons idle at 1 through reset → no outputs or pulses. Drive `button[0]`=0 → `out[0]`/`rise[0]` at +13; drive it back to 1 → `fall[0]` at +13.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and width helpers for the multi-channel debouncer.
package debounce_pkg;

  localparam int unsigned DB_CYCLES_SIM   = 10;
  localparam int unsigned DB_CYCLES_HW    = 500000;
  localparam int unsigned HOLD_CYCLES_DEF = 20;

  // Ceiling log2; clog2(0) and clog2(1) are both 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = clog2(max_val + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: input synchroniser, stability counter, edge pulses and long-press timer.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DB_CYCLES_SIM,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic out,
  output logic rise,
  output logic fall,
  output logic held,
  output logic long_pulse
);

  localparam int unsigned CntW = cnt_width(DB_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES);

  logic            sync1_q, sync2_q;
  logic            iv_q, iv_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            out_q, out_d;
  logic            rise_q, fall_q;

  always_comb begin
    iv_d  = iv_q;
    cnt_d = cnt_q;
    out_d = out_q;
    if (sync2_q != iv_q) begin
      iv_d  = sync2_q;
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      out_d = iv_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Inversion sits ahead of the synchroniser so reset state always means released.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      iv_q    <= 1'b0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= button ^ ACTIVE_LOW;
      sync2_q <= sync1_q;
      iv_q    <= iv_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= out_d & ~out_q;
      fall_q  <= ~out_d & out_q;
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

  if (HOLD_CYCLES == 0) begin : g_no_hold
    assign held       = 1'b0;
    assign long_pulse = 1'b0;
  end else begin : g_hold
    localparam int unsigned HoldW = cnt_width(HOLD_CYCLES);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES);

    logic [HoldW-1:0] hcnt_q, hcnt_d;
    logic             held_q, held_d;
    logic             lp_q, lp_d;

    // Timer restarts from 0 on the rising edge; held drops together with out.
    always_comb begin
      hcnt_d = hcnt_q;
      held_d = held_q;
      lp_d   = 1'b0;
      if (!out_d) begin
        hcnt_d = '0;
        held_d = 1'b0;
      end else if (!out_q) begin
        hcnt_d = '0;
      end else if (hcnt_q != HoldMax) begin
        hcnt_d = hcnt_q + 1'b1;
        if (hcnt_q == HoldMax - 1'b1) begin
          held_d = 1'b1;
          lp_d   = 1'b1;
        end
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        hcnt_q <= '0;
        held_q <= 1'b0;
        lp_q   <= 1'b0;
      end else begin
        hcnt_q <= hcnt_d;
        held_q <= held_d;
        lp_q   <= lp_d;
      end
    end

    assign held       = held_q;
    assign long_pulse = lp_q;
  end

endmodule

// File: rtl/debounce_multi.sv
// N-channel debouncer: independent debounce_ch instances packed onto vector ports.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH        = 5,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_SIM,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] held,
  output logic [N_CH-1:0] long_pulse
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .DB_CYCLES  (DB_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clock     (clock),
      .reset     (reset),
      .button    (button[i]),
      .out       (out[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .held      (held[i]),
      .long_pulse(long_pulse[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench: stimulus queues expected pulses, a negedge monitor matches observed ones.
module tb_debounce_multi;

  localparam int KRise = 0;
  localparam int KFall = 1;
  localparam int KLp   = 2;

  typedef struct {
    int dut;
    int kind;
    int ch;
    int cyc;
  } ev_t;

  logic       clock = 1'b0;
  logic       rst_a, rst_b;
  logic [4:0] btn_a, btn_b;
  logic [4:0] out_a, rise_a, fall_a, held_a, lp_a;
  logic [4:0] out_b, rise_b, fall_b, held_b, lp_b;

  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;
  ev_t exp_q[$];
  string kname[3] = '{"rise", "fall", "long_pulse"};

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  debounce_multi #(
    .N_CH(5), .DB_CYCLES(10), .HOLD_CYCLES(20), .ACTIVE_LOW(1'b0)
  ) u_dut_a (
    .clock(clock), .reset(rst_a), .button(btn_a), .out(out_a), .rise(rise_a),
    .fall(fall_a), .held(held_a), .long_pulse(lp_a)
  );

  debounce_multi #(
    .N_CH(5), .DB_CYCLES(10), .HOLD_CYCLES(20), .ACTIVE_LOW(1'b1)
  ) u_dut_b (
    .clock(clock), .reset(rst_b), .button(btn_b), .out(out_b), .rise(rise_b),
    .fall(fall_b), .held(held_b), .long_pulse(lp_b)
  );

  function automatic logic [4:0] pulses(input int d, input int k);
    if (d == 0) return (k == KRise) ? rise_a : (k == KFall) ? fall_a : lp_a;
    return (k == KRise) ? rise_b : (k == KFall) ? fall_b : lp_b;
  endfunction

  task automatic push(input int d, input int k, input int c, input int t);
    exp_q.push_back('{dut: d, kind: k, ch: c, cyc: t});
  endtask

  task automatic match(input int d, input int k, input int c);
    int idx;
    idx = -1;
    foreach (exp_q[i]) begin
      if (idx < 0 && exp_q[i].dut == d && exp_q[i].kind == k && exp_q[i].ch == c) idx = i;
    end
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL unexpected dut%0d %s[%0d] at cycle %0d: got pulse, required none",
               d, kname[k], c, cyc);
    end else begin
      if (exp_q[idx].cyc != cyc) begin
        errors++;
        $display("FAIL dut%0d %s[%0d] timing: got cycle %0d, required cycle %0d",
                 d, kname[k], c, cyc, exp_q[idx].cyc);
      end
      exp_q.delete(idx);
    end
  endtask

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 3; k++) begin
        for (int c = 0; c < 5; c++) begin
          logic [4:0] v;
          v = pulses(d, k);
          if (v[c] === 1'b1) match(d, k, c);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b, required %b", name, cyc, act, req);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    btn_a = '0;
    btn_b = '1;
    repeat (3) @(negedge clock);
    chk("reset_out_a", out_a, 5'b0);
    chk("reset_held_a", held_a, 5'b0);
    chk("reset_out_b", out_b, 5'b0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Single press on ch0 held past the long-press threshold.
    t0 = cyc;
    btn_a[0] = 1'b1;
    push(0, KRise, 0, t0 + 14);
    push(0, KLp, 0, t0 + 34);
    wait_until(t0 + 13); chk("t1_out_early", out_a, 5'b00000);
    wait_until(t0 + 14); chk("t1_out", out_a, 5'b00001);
    wait_until(t0 + 15); chk("t1_rise_gone", rise_a, 5'b00000);
    wait_until(t0 + 33); chk("t1_held_early", held_a, 5'b00000);
    wait_until(t0 + 34); chk("t1_held", held_a, 5'b00001);
    wait_until(t0 + 40);
    btn_a[0] = 1'b0;
    push(0, KFall, 0, t0 + 54);
    wait_until(t0 + 54); chk("t1_out_fall", out_a, 5'b00000);
    chk("t1_held_clr", held_a, 5'b00000);
    wait_until(t0 + 58);

    // Short 8-cycle glitch on ch1 never reaches the output.
    t0 = cyc;
    btn_a[1] = 1'b1;
    wait_until(t0 + 8);
    btn_a[1] = 1'b0;
    wait_until(t0 + 30); chk("t2_out", out_a, 5'b00000);

    // ch2 chatters every 3 cycles, then settles high.
    t0 = cyc;
    for (int k = 0; k < 10; k++) begin
      wait_until(t0 + 3 * k);
      btn_a[2] = (k % 2 == 0);
    end
    wait_until(t0 + 30);
    btn_a[2] = 1'b1;
    push(0, KRise, 2, t0 + 44);
    push(0, KLp, 2, t0 + 64);
    wait_until(t0 + 43); chk("t3_out_early", out_a, 5'b00000);
    wait_until(t0 + 44); chk("t3_out", out_a, 5'b00100);
    wait_until(t0 + 70);
    btn_a[2] = 1'b0;
    push(0, KFall, 2, t0 + 84);
    wait_until(t0 + 90);

    // ch3 long press for 60 cycles.
    t0 = cyc;
    btn_a[3] = 1'b1;
    push(0, KRise, 3, t0 + 14);
    push(0, KLp, 3, t0 + 34);
    wait_until(t0 + 34); chk("t4_held", held_a, 5'b01000);
    chk("t4_lp", lp_a, 5'b01000);
    wait_until(t0 + 35); chk("t4_lp_gone", lp_a, 5'b00000);
    wait_until(t0 + 60);
    btn_a[3] = 1'b0;
    push(0, KFall, 3, t0 + 74);
    wait_until(t0 + 73); chk("t4_held_before_fall", held_a, 5'b01000);
    wait_until(t0 + 74); chk("t4_held_clr", held_a, 5'b00000);
    chk("t4_out", out_a, 5'b00000);
    wait_until(t0 + 80);

    // ch0 and ch1 together: simultaneous pulses, released before long-press.
    t0 = cyc;
    btn_a[1:0] = 2'b11;
    push(0, KRise, 0, t0 + 14);
    push(0, KRise, 1, t0 + 14);
    wait_until(t0 + 14); chk("t4b_out", out_a, 5'b00011);
    wait_until(t0 + 15);
    btn_a[1:0] = 2'b00;
    push(0, KFall, 0, t0 + 29);
    push(0, KFall, 1, t0 + 29);
    wait_until(t0 + 29); chk("t4b_out_fall", out_a, 5'b00000);
    wait_until(t0 + 40);

    // ch4 held high with resets mid-count and after out has risen.
    t0 = cyc;
    btn_a[4] = 1'b1;
    wait_until(t0 + 6);
    rst_a = 1'b1;
    wait_until(t0 + 7);
    rst_a = 1'b0;
    chk("t5_out_rst1", out_a, 5'b00000);
    chk("t5_rise_rst1", rise_a, 5'b00000);
    push(0, KRise, 4, t0 + 21);
    wait_until(t0 + 20); chk("t5_out_early", out_a, 5'b00000);
    wait_until(t0 + 21); chk("t5_out", out_a, 5'b10000);
    wait_until(t0 + 29);
    rst_a = 1'b1;
    wait_until(t0 + 30);
    rst_a = 1'b0;
    chk("t5_out_rst2", out_a, 5'b00000);
    chk("t5_fall_rst2", fall_a, 5'b00000);
    push(0, KRise, 4, t0 + 44);
    push(0, KLp, 4, t0 + 64);
    wait_until(t0 + 44); chk("t5_out_again", out_a, 5'b10000);
    wait_until(t0 + 70);
    btn_a[4] = 1'b0;
    push(0, KFall, 4, t0 + 84);
    wait_until(t0 + 90);

    // Active-low instance: idle-high pins read as released.
    chk("t6_idle_out", out_b, 5'b00000);
    t0 = cyc;
    btn_b[0] = 1'b0;
    push(1, KRise, 0, t0 + 14);
    wait_until(t0 + 14); chk("t6_out", out_b, 5'b00001);
    wait_until(t0 + 18);
    btn_b[0] = 1'b1;
    push(1, KFall, 0, t0 + 32);
    wait_until(t0 + 32); chk("t6_out_fall", out_b, 5'b00000);
    wait_until(t0 + 40);

    foreach (exp_q[i]) begin
      checks++;
      errors++;
      $display("FAIL missing dut%0d %s[%0d]: got no pulse, required one at cycle %0d",
               exp_q[i].dut, kname[exp_q[i].kind], exp_q[i].ch, exp_q[i].cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
